// File: rtl/lab2_bcd_to_excess3_serial_if.sv
// lab2_bcd_to_excess3_serial_if
//   Groups the frame-side signals of the bit-serial BCD-to-Excess-3 encoder.
//   master : drives clr / in_valid / bit_in and observes the results
//   slave  : the encoder itself
//   Signals:
//     clr        frame abort (synchronous)
//     in_valid   bit_in qualified
//     bit_in     BCD bit, LSB first
//     out_valid  out_bit qualified (registered)
//     out_bit    Excess-3 bit, LSB first (registered)
//     E_out      last completed Excess-3 code word
//     v          last completed frame was BCD 0-9
//     frame_done one-cycle pulse on E_out/v update
//     busy       frame partially received
interface lab2_bcd_to_excess3_serial_if;
  logic       clr;
  logic       in_valid;
  logic       bit_in;
  logic       out_valid;
  logic       out_bit;
  logic [3:0] E_out;
  logic       v;
  logic       frame_done;
  logic       busy;

  modport master (
    output clr, in_valid, bit_in,
    input  out_valid, out_bit, E_out, v, frame_done, busy
  );

  modport slave (
    input  clr, in_valid, bit_in,
    output out_valid, out_bit, E_out, v, frame_done, busy
  );
endinterface

// File: rtl/lab2_bcd_to_excess3_serial.sv
// lab2_bcd_to_excess3_serial
//   Bit-serial BCD to Excess-3 encoder. A 4-bit digit arrives LSB first,
//   one bit per qualified cycle; a 7-state Mealy machine adds 0011 on the
//   fly and emits each Excess-3 bit one cycle later. At the end of each
//   frame the whole code word is presented in parallel together with a
//   BCD validity flag (digits 10-15 give E_out=0, v=0).
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    slave side of lab2_bcd_to_excess3_serial_if
module lab2_bcd_to_excess3_serial (
  input  logic                            clk,
  input  logic                            rst_n,
  lab2_bcd_to_excess3_serial_if.slave     bus
);

  // Sn = bit position, Cx = carry into that position.
  typedef enum logic [2:0] {
    S0   = 3'd0,
    S1C0 = 3'd1,
    S1C1 = 3'd2,
    S2C0 = 3'd3,
    S2C1 = 3'd4,
    S3C0 = 3'd5,
    S3C1 = 3'd6
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic       w_accept;
  logic       w_out;
  logic       w_last;
  logic [3:0] w_digit;
  logic [3:0] w_code;

  logic [2:0] r_in_sr;
  logic [2:0] r_out_sr;
  logic       r_out_valid;
  logic       r_out_bit;
  logic [3:0] r_e_out;
  logic       r_v;
  logic       r_frame_done;

  // Next-state / Mealy output. The addend is 0011, so positions 0 and 1
  // add a 1 and positions 2 and 3 add only the incoming carry.
  always_comb begin
    w_state_next = r_state;
    w_out        = 1'b0;
    w_accept     = bus.in_valid && !bus.clr;
    w_last       = (r_state == S3C0) || (r_state == S3C1);

    case (r_state)
      S0: begin
        w_out = ~bus.bit_in;
        if (w_accept) w_state_next = bus.bit_in ? S1C1 : S1C0;
      end
      S1C0: begin
        w_out = ~bus.bit_in;
        if (w_accept) w_state_next = bus.bit_in ? S2C1 : S2C0;
      end
      S1C1: begin
        w_out = bus.bit_in;
        if (w_accept) w_state_next = S2C1;
      end
      S2C0: begin
        w_out = bus.bit_in;
        if (w_accept) w_state_next = S3C0;
      end
      S2C1: begin
        // x + carry: a set bit generates the carry into position 3
        w_out = ~bus.bit_in;
        if (w_accept) w_state_next = bus.bit_in ? S3C1 : S3C0;
      end
      S3C0: begin
        w_out = bus.bit_in;
        if (w_accept) w_state_next = S0;
      end
      S3C1: begin
        // carry out of position 3 is dropped
        w_out = ~bus.bit_in;
        if (w_accept) w_state_next = S0;
      end
      default: begin
        w_out        = 1'b0;
        w_state_next = S0;
      end
    endcase

    if (bus.clr) w_state_next = S0;
  end

  // Shift registers fill from the top so that after three shifts bit 0
  // of the frame sits in [0].
  assign w_digit = {bus.bit_in, r_in_sr};
  assign w_code  = {w_out, r_out_sr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S0;
      r_in_sr      <= 3'b000;
      r_out_sr     <= 3'b000;
      r_out_valid  <= 1'b0;
      r_out_bit    <= 1'b0;
      r_e_out      <= 4'b0000;
      r_v          <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_out_valid  <= w_accept;
      r_frame_done <= w_accept && w_last;
      if (bus.clr) begin
        r_in_sr  <= 3'b000;
        r_out_sr <= 3'b000;
      end else if (w_accept) begin
        r_out_bit <= w_out;
        if (w_last) begin
          if (w_digit <= 4'd9) begin
            r_e_out <= w_code;
            r_v     <= 1'b1;
          end else begin
            r_e_out <= 4'b0000;
            r_v     <= 1'b0;
          end
        end else begin
          r_in_sr  <= {bus.bit_in, r_in_sr[2:1]};
          r_out_sr <= {w_out, r_out_sr[2:1]};
        end
      end
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_bit    = r_out_bit;
  assign bus.E_out      = r_e_out;
  assign bus.v          = r_v;
  assign bus.frame_done = r_frame_done;
  assign bus.busy       = (r_state != S0);

endmodule
